// File: rtl/dda_pkg.sv
// Shared constants for the DDA run controller: command opcodes, FSM states
// and power-on values of the posit parameter registers.
package dda_pkg;

    // Opcodes are full command bytes; WRITE is matched on its upper nibble only.
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h10;
    localparam logic [7:0] OP_RUN    = 8'h20;
    localparam logic [7:0] OP_HALT   = 8'h30;
    localparam logic [7:0] OP_RELOAD = 8'h40;
    localparam logic [7:0] OP_READ   = 8'h50;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARG_HI = 3'd1,
        ST_ARG_LO = 3'd2,
        ST_RUN    = 3'd3,
        ST_SEND   = 3'd4
    } state_e;

    localparam logic [15:0] ICX_DEF = 16'hC000;
    localparam logic [15:0] ICY_DEF = 16'h14CD;
    localparam logic [15:0] K_DEF   = 16'h14DD;
    localparam logic [15:0] D_DEF   = 16'h14DD;

    function automatic logic is_write_op(input logic [7:0] b);
        return b[7:4] == OP_WRITE[7:4];
    endfunction

endpackage

// File: rtl/dda_run_ctrl_if.sv
// Byte streams between the pin-level host and the run controller:
// command bytes in, state bytes out, each with a valid/ready handshake.
interface dda_run_ctrl_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output cmd_data, cmd_valid, out_ready,
        input  cmd_ready, out_data, out_valid
    );

    modport slave (
        input  cmd_data, cmd_valid, out_ready,
        output cmd_ready, out_data, out_valid
    );
endinterface

// File: rtl/dda_state_ser.sv
// Snapshots {x,y} and streams it out MSB byte first over a valid/ready
// handshake; o_done marks the handshake of the fourth byte.
module dda_state_ser #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    input  logic         i_out_ready,
    output logic [7:0]   o_out_data,
    output logic         o_out_valid,
    output logic         o_done
);

    logic [2*N-1:0] r_shift;
    logic [1:0]     r_cnt;
    logic           r_valid;
    logic           w_fire;

    assign w_fire      = r_valid & i_out_ready;
    assign o_out_data  = r_shift[2*N-1 -: 8];
    assign o_out_valid = r_valid;
    assign o_done      = w_fire && (r_cnt == 2'd3);

    // Load the snapshot, then shift one byte per accepted handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= {i_x, i_y};
            r_cnt   <= 2'd0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            r_shift <= {r_shift[2*N-9:0], 8'h00};
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dda_run_ctrl.sv
// Byte-command sequencer for the spring-mass DDA integrator: owns the posit
// parameter registers, drives dda reset/enable and serialises x/y on request.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | decode opcode byte; NOP/HALT/RELOAD/READ act immediately
//   ST_ARG_HI | wait for argument high byte (WRITE or RUN)
//   ST_ARG_LO | wait for argument low byte; commit param or start run
//   ST_RUN    | dda_en high, remaining steps counting down to 1
//   ST_SEND   | serialiser streaming x/y bytes, commands blocked
module dda_run_ctrl
    import dda_pkg::*;
#(
    parameter int N     = 16,
    parameter int ES    = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dda_run_ctrl_if.slave    bus,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    output logic [N-1:0]     icx,
    output logic [N-1:0]     icy,
    output logic [N-1:0]     k,
    output logic [N-1:0]     d,
    output logic             dda_rst,
    output logic             dda_en,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] step_count
);

    // Byte framing of words and of the step count assumes two bytes per word.
    if (N != 16 || ES < 0) begin : g_bad_cfg
        $error("dda_run_ctrl requires N == 16");
    end

    state_e           r_state;
    logic             r_is_run;
    logic [1:0]       r_sel;
    logic [7:0]       r_arg_hi;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_step_count;
    logic             r_dda_rst;
    logic             r_dda_en;
    logic             r_err;
    logic [N-1:0]     r_icx;
    logic [N-1:0]     r_icy;
    logic [N-1:0]     r_k;
    logic [N-1:0]     r_d;

    logic             w_accept;
    logic [7:0]       w_cmd;
    logic [N-1:0]     w_arg_word;
    logic [CNT_W-1:0] w_arg_cnt;
    logic             w_param_we;
    logic             w_ser_load;
    logic             w_ser_done;

    assign w_cmd       = bus.cmd_data;
    assign w_accept    = bus.cmd_valid & bus.cmd_ready;
    assign w_arg_word  = N'({r_arg_hi, w_cmd});
    assign w_arg_cnt   = CNT_W'({r_arg_hi, w_cmd});
    assign w_param_we  = (r_state == ST_ARG_LO) && w_accept && !r_is_run;
    assign w_ser_load  = (r_state == ST_IDLE) && w_accept && (w_cmd == OP_READ);

    assign bus.cmd_ready = (r_state != ST_SEND);
    assign busy          = (r_state != ST_IDLE);
    assign dda_rst       = r_dda_rst;
    assign dda_en        = r_dda_en;
    assign err           = r_err;
    assign step_count    = r_step_count;
    assign icx           = r_icx;
    assign icy           = r_icy;
    assign k             = r_k;
    assign d             = r_d;

    dda_state_ser #(.N(N)) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_ser_load),
        .i_x         (x),
        .i_y         (y),
        .i_out_ready (bus.out_ready),
        .o_out_data  (bus.out_data),
        .o_out_valid (bus.out_valid),
        .o_done      (w_ser_done)
    );

    // Command decode, run down-counter, step counter and dda strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_is_run     <= 1'b0;
            r_sel        <= 2'd0;
            r_arg_hi     <= 8'h00;
            r_remaining  <= '0;
            r_step_count <= '0;
            r_dda_rst    <= 1'b1;
            r_dda_en     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_dda_rst <= 1'b0;
            if (r_dda_en) begin
                r_step_count <= r_step_count + CNT_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_cmd == OP_NOP) begin
                            r_err <= 1'b0;
                        end else if (is_write_op(w_cmd)) begin
                            if (w_cmd[3:2] != 2'b00) begin
                                r_err <= 1'b1;
                            end else begin
                                r_sel    <= w_cmd[1:0];
                                r_is_run <= 1'b0;
                                r_state  <= ST_ARG_HI;
                            end
                        end else if (w_cmd == OP_RUN) begin
                            r_is_run <= 1'b1;
                            r_state  <= ST_ARG_HI;
                        end else if (w_cmd == OP_HALT) begin
                            r_state <= ST_IDLE;
                        end else if (w_cmd == OP_RELOAD) begin
                            r_dda_rst    <= 1'b1;
                            r_step_count <= '0;
                        end else if (w_cmd == OP_READ) begin
                            r_state <= ST_SEND;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ARG_HI: begin
                    if (w_accept) begin
                        r_arg_hi <= w_cmd;
                        r_state  <= ST_ARG_LO;
                    end
                end
                ST_ARG_LO: begin
                    if (w_accept) begin
                        if (r_is_run && (w_arg_cnt != '0)) begin
                            r_remaining <= w_arg_cnt;
                            r_dda_en    <= 1'b1;
                            r_state     <= ST_RUN;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept && (w_cmd == OP_HALT)) begin
                        r_dda_en <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        if (w_accept) begin
                            r_err <= 1'b1;
                        end
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_dda_en <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_ser_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Parameter registers change only when a WRITE argument completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_icx <= N'(ICX_DEF);
            r_icy <= N'(ICY_DEF);
            r_k   <= N'(K_DEF);
            r_d   <= N'(D_DEF);
        end else if (w_param_we) begin
            case (r_sel)
                2'd0:    r_icx <= w_arg_word;
                2'd1:    r_icy <= w_arg_word;
                2'd2:    r_k   <= w_arg_word;
                default: r_d   <= w_arg_word;
            endcase
        end
    end

endmodule
